// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine paying path: state codes,
// seven-segment glyphs and the binary-to-BCD helper used by the display.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_NONE   = 3'd0,
        ST_START  = 3'd1,
        ST_SELECT = 3'd2,
        ST_CHECK  = 3'd3,
        ST_TIME   = 3'd4,
        ST_PAY    = 3'd5,
        ST_CHANGE = 3'd6,
        ST_RETURN = 3'd7
    } pay_state_e;

    // Segment order is {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] GLYPH_BLANK = 8'h00;
    localparam logic [7:0] GLYPH_E     = 8'h79;
    localparam logic [7:0] GLYPH_F     = 8'h71;
    localparam logic [7:0] GLYPH_D     = 8'h5E;
    localparam logic [7:0] GLYPH_DASH  = 8'h40;

    function automatic logic [7:0] seg7(input logic [3:0] digit);
        logic [7:0] g;
        case (digit)
            4'd0:    g = 8'h3F;
            4'd1:    g = 8'h06;
            4'd2:    g = 8'h5B;
            4'd3:    g = 8'h4F;
            4'd4:    g = 8'h66;
            4'd5:    g = 8'h6D;
            4'd6:    g = 8'h7D;
            4'd7:    g = 8'h07;
            4'd8:    g = 8'h7F;
            4'd9:    g = 8'h6F;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Double-dabble: returns {hundreds, tens, ones} for 0..255.
    function automatic logic [11:0] bin2bcd(input logic [7:0] bin);
        logic [19:0] sr;
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5)  sr[11:8]  = sr[11:8] + 4'd3;
            if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
            if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
            sr = sr << 1;
        end
        return sr[19:8];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer: two-flop synchronizer followed by a stability counter; the
// output only follows an input level that held for DB_CYCLES clocks.
module key_debounce
    import vend_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        cnt_d  = cnt_q + CNT_W'(1);
        dout_d = dout_q;
        if (sync_q[1] == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            dout_d = sync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/pay_display_unit.sv
// Status display for the paying FSM: scans an 8-digit multiplexed
// seven-segment display and drives the per-state status LEDs.
module pay_display_unit
    import vend_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkout1,
    input  logic       clkout2,
    input  logic [7:0] num1,
    input  logic [7:0] num2,
    input  logic [7:0] num3,
    input  logic [7:0] num4,
    input  logic [7:0] paid_money,
    input  logic [7:0] change,
    input  logic [2:0] state,
    input  logic       not_enough,
    input  logic [7:0] left_time,
    input  logic       money_enough,
    input  logic       done,
    input  logic [7:0] require_money,
    output logic [7:0] segment_led,
    output logic [7:0] seg_en,
    output logic [6:0] led_en
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [7:0]       seg_en_q, seg_en_d;
    logic [7:0]       segment_led_q, segment_led_d;
    logic [6:0]       led_en_q, led_en_d;

    logic             blink_slow, blink_fast;
    logic [7:0][7:0]  glyph_map;
    logic [11:0]      num1_bcd, num2_bcd, num3_bcd, num4_bcd;
    logic [11:0]      time_bcd, req_bcd, paid_bcd, change_bcd;
    pay_state_e       cur_state;
    logic             unused_money_enough;

    // money_enough has no effect on what is displayed.
    assign unused_money_enough = money_enough;
    assign cur_state = pay_state_e'(state);

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_slow (
        .clk  (clk),
        .rst  (rst),
        .din  (clkout1),
        .dout (blink_slow)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_fast (
        .clk  (clk),
        .rst  (rst),
        .din  (clkout2),
        .dout (blink_fast)
    );

    assign num1_bcd   = bin2bcd(num1);
    assign num2_bcd   = bin2bcd(num2);
    assign num3_bcd   = bin2bcd(num3);
    assign num4_bcd   = bin2bcd(num4);
    assign time_bcd   = bin2bcd(left_time);
    assign req_bcd    = bin2bcd(require_money);
    assign paid_bcd   = bin2bcd(paid_money);
    assign change_bcd = bin2bcd(change);

    // Two-digit fields drop the hundreds digit, i.e. show value mod 100.
    always_comb begin
        glyph_map = '0;
        case (cur_state)
            ST_START: glyph_map = {8{GLYPH_DASH}};
            ST_SELECT, ST_CHECK: begin
                if (cur_state == ST_CHECK && not_enough) begin
                    glyph_map[7] = GLYPH_E;
                end else begin
                    glyph_map[7] = seg7(num1_bcd[7:4]);
                    glyph_map[6] = seg7(num1_bcd[3:0]);
                    glyph_map[5] = seg7(num2_bcd[7:4]);
                    glyph_map[4] = seg7(num2_bcd[3:0]);
                    glyph_map[3] = seg7(num3_bcd[7:4]);
                    glyph_map[2] = seg7(num3_bcd[3:0]);
                    glyph_map[1] = seg7(num4_bcd[7:4]);
                    glyph_map[0] = seg7(num4_bcd[3:0]);
                end
            end
            ST_TIME, ST_PAY: begin
                glyph_map[7] = seg7(time_bcd[7:4]);
                glyph_map[6] = seg7(time_bcd[3:0]);
                glyph_map[5] = seg7(req_bcd[11:8]);
                glyph_map[4] = seg7(req_bcd[7:4]);
                glyph_map[3] = seg7(req_bcd[3:0]);
                glyph_map[2] = seg7(paid_bcd[11:8]);
                glyph_map[1] = seg7(paid_bcd[7:4]);
                glyph_map[0] = seg7(paid_bcd[3:0]);
            end
            ST_CHANGE, ST_RETURN: begin
                if (cur_state == ST_RETURN) glyph_map[7] = GLYPH_D;
                else                        glyph_map[7] = blink_fast ? GLYPH_F : GLYPH_BLANK;
                glyph_map[5] = seg7(req_bcd[11:8]);
                glyph_map[4] = seg7(req_bcd[7:4]);
                glyph_map[3] = seg7(req_bcd[3:0]);
                glyph_map[2] = seg7(change_bcd[11:8]);
                glyph_map[1] = seg7(change_bcd[7:4]);
                glyph_map[0] = seg7(change_bcd[3:0]);
            end
            default: glyph_map = '0;
        endcase
    end

    // Segments are fetched for the next digit index so they change together with seg_en.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 3'd1;
        end
        seg_en_d      = 8'd1 << digit_idx_d;
        segment_led_d = glyph_map[digit_idx_d];
    end

    always_comb begin
        led_en_d = '0;
        if (cur_state != ST_NONE) led_en_d = 7'd1 << (state - 3'd1);
        if (cur_state == ST_CHECK && not_enough) led_en_d = {7{blink_slow}};
        if (cur_state == ST_RETURN && done) led_en_d[6] = led_en_d[6] | blink_fast;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            seg_en_q      <= 8'b0000_0001;
            segment_led_q <= '0;
            led_en_q      <= '0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            seg_en_q      <= seg_en_d;
            segment_led_q <= segment_led_d;
            led_en_q      <= led_en_d;
        end
    end

    assign seg_en      = seg_en_q;
    assign segment_led = segment_led_q;
    assign led_en      = led_en_q;

endmodule

// File: tb/tb_pay_display_unit.sv
// Randomized self-checking bench for pay_display_unit against a
// behavioural display model built from decimal arithmetic.
module tb_pay_display_unit;

    localparam int SCAN_DIV  = 4;
    localparam int DB_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clkout1 = 1'b0, clkout2 = 1'b0;
    logic [7:0] num1 = '0, num2 = '0, num3 = '0, num4 = '0;
    logic [7:0] paid_money = '0, change = '0, left_time = '0, require_money = '0;
    logic [2:0] state = '0;
    logic       not_enough = 1'b0, money_enough = 1'b0, done = 1'b0;
    logic [7:0] segment_led, seg_en;
    logic [6:0] led_en;

    int total = 0;
    int bad   = 0;

    logic [7:0] font [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    pay_display_unit #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .clkout1       (clkout1),
        .clkout2       (clkout2),
        .num1          (num1),
        .num2          (num2),
        .num3          (num3),
        .num4          (num4),
        .paid_money    (paid_money),
        .change        (change),
        .state         (state),
        .not_enough    (not_enough),
        .left_time     (left_time),
        .money_enough  (money_enough),
        .done          (done),
        .require_money (require_money),
        .segment_led   (segment_led),
        .seg_en        (seg_en),
        .led_en        (led_en)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Expected glyph for one digit position, assuming slow inputs have settled.
    function automatic logic [7:0] model_digit(input int pos);
        logic [7:0] m [8];
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        case (state)
            3'd1: for (int i = 0; i < 8; i++) m[i] = 8'h40;
            3'd2, 3'd3: begin
                if (state == 3'd3 && not_enough) m[7] = 8'h79;
                else begin
                    m[7] = font[(num1 % 100) / 10]; m[6] = font[num1 % 10];
                    m[5] = font[(num2 % 100) / 10]; m[4] = font[num2 % 10];
                    m[3] = font[(num3 % 100) / 10]; m[2] = font[num3 % 10];
                    m[1] = font[(num4 % 100) / 10]; m[0] = font[num4 % 10];
                end
            end
            3'd4, 3'd5: begin
                m[7] = font[(left_time % 100) / 10]; m[6] = font[left_time % 10];
                m[5] = font[require_money / 100];
                m[4] = font[(require_money / 10) % 10];
                m[3] = font[require_money % 10];
                m[2] = font[paid_money / 100];
                m[1] = font[(paid_money / 10) % 10];
                m[0] = font[paid_money % 10];
            end
            3'd6, 3'd7: begin
                if (state == 3'd7) m[7] = 8'h5E;
                else               m[7] = clkout2 ? 8'h71 : 8'h00;
                m[5] = font[require_money / 100];
                m[4] = font[(require_money / 10) % 10];
                m[3] = font[require_money % 10];
                m[2] = font[change / 100];
                m[1] = font[(change / 10) % 10];
                m[0] = font[change % 10];
            end
            default: ;
        endcase
        return m[pos];
    endfunction

    function automatic logic [6:0] model_led();
        logic [6:0] l;
        l = '0;
        if (state != 3'd0) l[state - 3'd1] = 1'b1;
        if (state == 3'd3 && not_enough) l = {7{clkout1}};
        if (state == 3'd7 && done) l[6] = l[6] | clkout2;
        return l;
    endfunction

    task automatic apply_stimulus(input logic [2:0] st, input logic [7:0] n1, n2, n3, n4,
                                  input logic [7:0] lt, rm, pm, ch,
                                  input logic ne, dn, c1, c2);
        @(negedge clk);
        state = st; num1 = n1; num2 = n2; num3 = n3; num4 = n4;
        left_time = lt; require_money = rm; paid_money = pm; change = ch;
        not_enough = ne; done = dn; clkout1 = c1; clkout2 = c2;
        money_enough = $urandom_range(1);
        repeat (DB_CYCLES + 4) @(posedge clk);
    endtask

    // One full scan frame: every cycle the enabled digit must show the model glyph.
    task automatic check_frame(input string tag);
        for (int n = 0; n < 8 * SCAN_DIV; n++) begin
            int idx;
            @(posedge clk);
            #1;
            idx = -1;
            for (int b = 0; b < 8; b++) if (seg_en == (8'd1 << b)) idx = b;
            if (idx < 0) check_output({tag, "_seg_en_onehot"}, seg_en, 8'h01);
            else         check_output({tag, "_digit"}, segment_led, model_digit(idx));
        end
        check_output({tag, "_led"}, led_en, model_led());
    endtask

    task automatic wait_led(input string tag, input logic [6:0] target, input int exp_cycles);
        int k;
        k = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (led_en == target) begin
                k = i;
                break;
            end
        end
        check_output(tag, k, exp_cycles);
    endtask

    initial begin
        int glitch;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_seg_en", seg_en, 8'h01);
        check_output("reset_segment_led", segment_led, 8'h00);
        check_output("reset_led_en", led_en, 7'h00);
        rst = 1'b1;

        for (int k = 1; k <= 8; k++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1;
            check_output($sformatf("walk_%0d", k), seg_en, 8'd1 << (k % 8));
        end

        apply_stimulus(3'd2, 8'd3, 8'd12, 8'd0, 8'd99, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("select");
        check_output("select_led_const", led_en, 7'b0000010);

        apply_stimulus(3'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd26, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("time");
        check_output("time_led_const", led_en, 7'b0001000);

        apply_stimulus(3'd2, 8'd100, 8'd255, 8'd199, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("mod100");

        apply_stimulus(3'd3, 8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_frame("err_on");
        check_output("err_led_on", led_en, 7'h7F);
        @(negedge clk) clkout1 = 1'b0;
        wait_led("blink_fall_latency", 7'h00, DB_CYCLES + 3);

        @(negedge clk) clkout1 = 1'b1;
        repeat (5) @(negedge clk);
        clkout1 = 1'b0;
        glitch = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (led_en != 7'h00) glitch++;
        end
        check_output("glitch_filtered", glitch, 0);

        @(negedge clk) clkout1 = 1'b1;
        wait_led("blink_rise_latency", 7'h7F, DB_CYCLES + 3);

        apply_stimulus(3'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd43, 8'd60, 8'd17, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("change_c2lo");
        apply_stimulus(3'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd43, 8'd60, 8'd17, 1'b0, 1'b0, 1'b0, 1'b1);
        check_frame("change_c2hi");

        apply_stimulus(3'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd120, 8'd0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b1);
        check_frame("return");
        apply_stimulus(3'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("start");
        apply_stimulus(3'd0, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("illegal");

        for (int r = 0; r < 25; r++) begin
            apply_stimulus(3'($urandom_range(7)),
                           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check_frame($sformatf("rand%0d", r));
        end

        repeat (SCAN_DIV * 3 + 1) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("midscan_reset_seg_en", seg_en, 8'h01);
        check_output("midscan_reset_segment_led", segment_led, 8'h00);
        check_output("midscan_reset_led_en", led_en, 7'h00);
        @(negedge clk) rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
